// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - door lock operating controller; lockout state built only with LOCKOUT_EN
// data_setup_new = {bip_ativado, bip_time[7:0], tranca_aut_time[7:0], senha_master, senha_1, senha_2, senha_3, senha_4}
module lock_controller #(
   parameter int TICK_CYCLES = 50_000_000
`ifdef LOCKOUT_EN
   ,
   parameter int MAX_FAIL    = 3,
   parameter int LOCKOUT_S   = 30
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [79:0]  digitos_value,
   input  logic         digitos_valid,
   input  logic         porta_aberta,
   input  logic         botao_interno,
   input  logic [416:0] data_setup_new,
   input  logic         data_setup_ok,
   output logic         setup_on,
   output logic         tranca,
   output logic         bip,
   output logic         display_en,
   output logic [23:0]  bcd_pac
);
   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_MAX    = PW'(TICK_CYCLES - 1);
   localparam logic [79:0]   ALL_F      = {20{4'hF}};
   localparam logic [79:0]   ALL_E      = {20{4'hE}};
   localparam logic [79:0]   SETUP_CODE = {{19{4'hF}}, 4'hA};
   localparam logic [79:0]   MASTER_RST = {{16{4'hF}}, 16'h1234};
   localparam logic [23:0]   BLANK      = 24'hBBBBBB;

   typedef enum logic [2:0] {
      TRANCADA, VALIDAR, DESTRANCADA, PORTA_ABERTA, SETUP
`ifdef LOCKOUT_EN
      , BLOQUEIO
`endif
   } state_t;

   state_t        state, next_state;
   logic [PW-1:0] pre, pre_n;
   logic [7:0]    cnt, cnt_n, cnt_dec;
   logic          tick, expired, match_r, match_n, cfg_load, entry_ok, entry_match;
   logic          bip_ativado;
   logic [7:0]    bip_time, aut_time;
   logic [399:0]  senhas;
   logic          tranca_n, bip_n, setup_on_n, display_en_n;
   logic [23:0]   bcd_n;
`ifdef LOCKOUT_EN
   logic [7:0]    fail, fail_n;
`endif

   function automatic logic [7:0] to_bcd(input logic [7:0] v);
      return {4'((v / 8'd10) % 8'd10), 4'(v % 8'd10)};
   endfunction

   assign entry_ok = digitos_valid && (digitos_value != ALL_E) && (digitos_value != ALL_F);

   // Empty (all-0xF) password slots must never unlock.
   always_comb begin
      entry_match = 1'b0;
      for (int i = 0; i < 5; i++)
         if (senhas[80*i +: 80] != ALL_F && senhas[80*i +: 80] == digitos_value)
            entry_match = 1'b1;
   end

   always_comb begin
      next_state = state;
      match_n    = match_r;
      cfg_load   = 1'b0;
`ifdef LOCKOUT_EN
      fail_n     = fail;
`endif
      tick    = (pre == '0);
      pre_n   = tick ? PRE_MAX : pre - PW'(1);
      cnt_dec = (tick && cnt != 8'd0) ? cnt - 8'd1 : cnt;
      expired = tick && (cnt <= 8'd1);
      cnt_n   = cnt_dec;

      case (state)
         TRANCADA: begin
            if (botao_interno) next_state = DESTRANCADA;
            else if (entry_ok) begin
               next_state = VALIDAR;
               match_n    = entry_match;
            end
         end
         VALIDAR: begin
            if (match_r) begin
               next_state = DESTRANCADA;
`ifdef LOCKOUT_EN
               fail_n     = 8'd0;
`endif
            end else begin
`ifdef LOCKOUT_EN
               fail_n     = fail + 8'd1;
               next_state = (fail_n >= 8'(MAX_FAIL)) ? BLOQUEIO : TRANCADA;
`else
               next_state = TRANCADA;
`endif
            end
         end
         DESTRANCADA: begin
            if (porta_aberta)                                        next_state = PORTA_ABERTA;
            else if (botao_interno)                                  next_state = TRANCADA;
            else if (digitos_valid && digitos_value == SETUP_CODE)   next_state = SETUP;
            else if (expired)                                        next_state = TRANCADA;
         end
         PORTA_ABERTA: if (!porta_aberta) next_state = DESTRANCADA;
         SETUP: begin
            if (data_setup_ok) begin
               cfg_load   = 1'b1;
               next_state = DESTRANCADA;
            end
         end
`ifdef LOCKOUT_EN
         BLOQUEIO: begin
            if (expired) begin
               next_state = TRANCADA;
               fail_n     = 8'd0;
            end
         end
`endif
         default: next_state = TRANCADA;
      endcase

      // Every state entry restarts a full second and loads that state's duration.
      if (next_state != state) begin
         pre_n = PRE_MAX;
         case (next_state)
            DESTRANCADA:  cnt_n = cfg_load ? data_setup_new[407:400] : aut_time;
            PORTA_ABERTA: cnt_n = bip_time;
`ifdef LOCKOUT_EN
            BLOQUEIO:     cnt_n = 8'(LOCKOUT_S);
`endif
            default:      cnt_n = 8'd0;
         endcase
      end

      tranca_n     = 1'b1;
      bip_n        = 1'b0;
      setup_on_n   = 1'b0;
      display_en_n = 1'b1;
      bcd_n        = BLANK;
      case (next_state)
         DESTRANCADA: begin
            tranca_n = 1'b0;
            bcd_n    = {16'hBBBB, to_bcd(cnt_n)};
         end
         PORTA_ABERTA: begin
            tranca_n = 1'b0;
            bip_n    = bip_ativado && (cnt_n == 8'd0);
            bcd_n    = {16'hBBBB, to_bcd(cnt_n)};
         end
         SETUP: begin
            tranca_n     = 1'b0;
            display_en_n = 1'b0;
            setup_on_n   = (state != SETUP);
         end
`ifdef LOCKOUT_EN
         BLOQUEIO: bcd_n = {16'hEBBB, to_bcd(cnt_n)};
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= TRANCADA;
         pre         <= PRE_MAX;
         cnt         <= 8'd0;
         match_r     <= 1'b0;
         bip_ativado <= 1'b1;
         bip_time    <= 8'd5;
         aut_time    <= 8'd5;
         senhas      <= {MASTER_RST, ALL_F, ALL_F, ALL_F, ALL_F};
         tranca      <= 1'b1;
         bip         <= 1'b0;
         setup_on    <= 1'b0;
         display_en  <= 1'b1;
         bcd_pac     <= BLANK;
`ifdef LOCKOUT_EN
         fail        <= 8'd0;
`endif
      end else begin
         state      <= next_state;
         pre        <= pre_n;
         cnt        <= cnt_n;
         match_r    <= match_n;
         tranca     <= tranca_n;
         bip        <= bip_n;
         setup_on   <= setup_on_n;
         display_en <= display_en_n;
         bcd_pac    <= bcd_n;
`ifdef LOCKOUT_EN
         fail       <= fail_n;
`endif
         if (cfg_load) begin
            bip_ativado <= data_setup_new[416];
            bip_time    <= data_setup_new[415:408];
            aut_time    <= data_setup_new[407:400];
            senhas      <= data_setup_new[399:0];
         end
      end
   end
endmodule
